// File: rtl/mod6343_pkg.sv
// Shared constants and record types for the mod-6343 reducer scheduler.
// Field widths in rsp_t are upper bounds; instances use the low bits they need.
package mod6343_pkg;

  localparam int Q         = 6343;
  localparam int QH        = 3171;
  localparam int IN_W      = 35;
  localparam int OUT_W     = 13;
  localparam int MAX_ID_W  = 3;
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_TAG_W-1:0] tag;
    logic [OUT_W-1:0]     data;
  } rsp_t;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod6343_rr_arb.sv
// Round-robin picker: first requester strictly after ptr (wrapping) wins.
// Purely combinational; the caller owns the pointer register.
module mod6343_rr_arb
  import mod6343_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grantIdx,
  output logic            grantAny
);

  logic [IDW-1:0]  candIdx [NREQ];
  logic [NREQ-1:0] candHit;

  // Candidate gi is the requester gi+1 positions after the pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : gCand
    assign candIdx[gi] = IDW'((int'(ptr) + gi + 1) % NREQ);
    assign candHit[gi] = req[candIdx[gi]];
  end

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (candHit[k]) begin
        grant              = '0;
        grant[candIdx[k]]  = 1'b1;
        grantIdx           = candIdx[k];
        grantAny           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod6343_red_sched.sv
// Shares one fixed-latency mod-6343 reducer among NREQ requesters, tracking
// id/tag alongside each operand and buffering results in a credit-guarded FIFO.
module mod6343_red_sched
  import mod6343_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int RED_LAT = 3,
  parameter int TAGW    = 4,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IN_W-1:0]   req_data,
  input  logic [NREQ*TAGW-1:0]   req_tag,
  output logic [NREQ-1:0]        req_ready,
  output logic [IN_W-1:0]        red_in,
  input  logic [OUT_W-1:0]       red_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAGW-1:0]        rsp_tag,
  output logic [OUT_W-1:0]       rsp_data
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);   // DEPTH must be a power of two >= 2

  logic [IN_W-1:0] reqDataArr [NREQ];
  logic [TAGW-1:0] reqTagArr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : gUnpack
    assign reqDataArr[gi] = req_data[IN_W*gi +: IN_W];
    assign reqTagArr[gi]  = req_tag[TAGW*gi +: TAGW];
  end

  logic [IDW-1:0]  ptrReg;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grantIdx;
  logic            grantAny;

  mod6343_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) uArb (
    .req      (req_valid),
    .ptr      (ptrReg),
    .grant    (grant),
    .grantIdx (grantIdx),
    .grantAny (grantAny)
  );

  logic [CW-1:0] credReg;
  logic          issueOk;
  logic          accept;
  logic          pop;

  // A pop in the same cycle does not free a credit; keeps issue off the pop path.
  assign issueOk   = credReg < CW'(DEPTH);
  assign req_ready = grant & {NREQ{issueOk}};
  assign accept    = grantAny & issueOk;
  assign pop       = rsp_valid & rsp_ready;

  logic [RED_LAT:0]           pipeValid;
  logic [RED_LAT:0][IDW-1:0]  pipeId;
  logic [RED_LAT:0][TAGW-1:0] pipeTag;

  logic [PW:0] wrPtr;
  logic [PW:0] wrPtrVis;
  logic [PW:0] rdPtr;
  logic        push;
  logic        fifoFull;
  rsp_t        pushEntry;
  rsp_t        mem [DEPTH];

  assign push     = pipeValid[RED_LAT];
  assign fifoFull = (wrPtr - rdPtr) == (PW+1)'(DEPTH);

  always_comb begin
    pushEntry      = '0;
    pushEntry.id   = MAX_ID_W'(pipeId[RED_LAT]);
    pushEntry.tag  = MAX_TAG_W'(pipeTag[RED_LAT]);
    pushEntry.data = red_out;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptrReg    <= IDW'(NREQ - 1);
      credReg   <= '0;
      red_in    <= '0;
      pipeValid <= '0;
      pipeId    <= '0;
      pipeTag   <= '0;
      wrPtr     <= '0;
      wrPtrVis  <= '0;
      rdPtr     <= '0;
    end else begin
      if (accept) begin
        ptrReg <= grantIdx;
      end
      unique case ({accept, pop})
        2'b10:   credReg <= credReg + CW'(1);
        2'b01:   credReg <= credReg - CW'(1);
        default: credReg <= credReg;
      endcase
      red_in    <= accept ? reqDataArr[grantIdx] : '0;
      // The id/tag pipeline is one stage longer than the reducer so its exit
      // lines up with red_out holding the matching result.
      pipeValid <= {pipeValid[RED_LAT-1:0], accept};
      pipeId    <= {pipeId[RED_LAT-1:0], grantIdx};
      pipeTag   <= {pipeTag[RED_LAT-1:0], reqTagArr[grantIdx]};
      if (push) begin
        wrPtr <= wrPtr + (PW+1)'(1);
      end
      // Writes become visible to the consumer one cycle after they land.
      wrPtrVis <= wrPtr;
      if (pop) begin
        rdPtr <= rdPtr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset && push) begin
      mem[wrPtr[PW-1:0]] <= pushEntry;
    end
  end

  assign rsp_valid = rdPtr != wrPtrVis;
  assign rsp_id    = rsp_valid ? mem[rdPtr[PW-1:0]].id[IDW-1:0]   : '0;
  assign rsp_tag   = rsp_valid ? mem[rdPtr[PW-1:0]].tag[TAGW-1:0] : '0;
  assign rsp_data  = rsp_valid ? mem[rdPtr[PW-1:0]].data          : '0;

  noOverflow: assert property (@(posedge clk) disable iff (Reset) push |-> !fifoFull);

endmodule
